distortion_mc: RTL

- Multi-channel, parametrised successor of the single-channel distortion stage.
- Applies a selectable integer gain, then either a continuous piecewise soft clip or a hard clip, to NUM_CH samples per transaction.
- Uses one time-shared multiply/clip datapath.
- Sits in the audio effects chain using the same cs/my_turn/done turn-taking handshake as the other effect blocks.

---
 rtl/distortion_pkg.sv | 29 ++
 rtl/dist_clip_core.sv | 57 +++++
 rtl/distortion_mc.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/distortion_pkg.sv
// Shared types and defaults for the multi-channel distortion stage.
// Both the top level and the clip core import this package.
package distortion_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CLIP,
        S_DONE
    } state_e;

    localparam int          DEFAULT_THRESH     = 10922;
    localparam logic [11:0] DEFAULT_GAIN_TABLE = {4'd6, 4'd4, 4'd1};

    function automatic int preset_next(input int idx, input int num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

    // Largest positive value of a w-bit two's complement sample, widened to 64 bits.
    function automatic longint sample_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Most negative value of a w-bit two's complement sample, widened to 64 bits.
    function automatic longint sample_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/dist_clip_core.sv
// Combinational transfer curve: soft piecewise clip or saturating hard clip
// of a full-precision product, reduced to a W-bit sample.
module dist_clip_core
    import distortion_pkg::*;
#(
    parameter int W  = 16,
    parameter int PW = 22,
    parameter int T  = DEFAULT_THRESH
) (
    input  logic signed [PW-1:0] p_i,
    input  logic                 hard_i,
    output logic signed [W-1:0]  y_o
);

    // Two guard bits so that 2P and P+T can never overflow.
    localparam int EW = PW + 2;

    localparam logic signed [EW-1:0] T1    = EW'(T);
    localparam logic signed [EW-1:0] T2    = EW'(2 * T);
    localparam logic signed [EW-1:0] LIM_P = EW'(sample_max(W));
    localparam logic signed [EW-1:0] LIM_N = EW'(sample_min(W));

    localparam logic signed [W-1:0] Y_MAXP = W'(sample_max(W));
    localparam logic signed [W-1:0] Y_MAXN = W'(sample_min(W));

    logic signed [EW-1:0] p_e;
    logic signed [EW-1:0] dbl;

    always_comb begin
        p_e = {{2{p_i[PW-1]}}, p_i};
        dbl = p_e <<< 1;
        y_o = '0;
        if (hard_i) begin
            if (dbl > LIM_P) begin
                y_o = Y_MAXP;
            end else if (dbl < LIM_N) begin
                y_o = Y_MAXN;
            end else begin
                y_o = W'(dbl);
            end
        end else begin
            // Segments meet at +/-T (2T either side) and at +/-2T (MAXP/MAXN).
            if (p_e >= T2) begin
                y_o = Y_MAXP;
            end else if (p_e >= T1) begin
                y_o = W'(p_e + T1);
            end else if (p_e > -T1) begin
                y_o = W'(dbl);
            end else if (p_e > -T2) begin
                y_o = W'(p_e - T1);
            end else begin
                y_o = Y_MAXN;
            end
        end
    end

endmodule

// File: rtl/distortion_mc.sv
// Multi-channel distortion stage: per-channel gain then clip, one shared
// multiply/clip datapath, cs/my_turn/done turn-taking handshake.
//
// state  | meaning
// S_IDLE | waiting for cs & my_turn; operands latched on start
// S_MUL  | product register loaded for channel ch
// S_CLIP | clipped result written to data_out[ch]
// S_DONE | one-cycle done pulse, data_out complete
module distortion_mc
    import distortion_pkg::*;
#(
    parameter int                                DATA_WIDTH  = 16,
    parameter int                                NUM_CH      = 2,
    parameter int                                GAIN_W      = 4,
    parameter int                                NUM_PRESETS = 3,
    parameter int                                OPT_W       = 2,
    parameter logic [NUM_PRESETS*GAIN_W-1:0]     GAIN_TABLE  = DEFAULT_GAIN_TABLE,
    parameter int                                THRESH      = DEFAULT_THRESH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cs,
    input  logic                            my_turn,
    input  logic                            control_key1,
    input  logic                            hard_mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    data_in,
    output logic                            done,
    output logic [NUM_CH*DATA_WIDTH-1:0]    data_out,
    output logic [OPT_W-1:0]                option_output,
    output logic [OPT_W-1:0]                available_options
);

    localparam int W    = DATA_WIDTH;
    localparam int PW   = W + GAIN_W + 2;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e state_q, state_d;
    logic   start_en, mul_en, clip_en, last_ch;

    logic              key_q;
    logic              key_rise;
    logic [OPT_W-1:0]  preset_q, preset_d;
    logic [GAIN_W-1:0] cur_gain;

    logic signed [W-1:0]  samp_q [NUM_CH];
    logic signed [W-1:0]  dout_q [NUM_CH];
    logic [GAIN_W-1:0]    gain_q;
    logic                 hard_q;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [PW-1:0] samp_ext, gain_ext;
    logic signed [W-1:0]  clip_y;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cs && my_turn) state_d = S_MUL;
            S_MUL:  state_d = S_CLIP;
            S_CLIP: state_d = last_ch ? S_DONE : S_MUL;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done     = (state_q == S_DONE);
        start_en = (state_q == S_IDLE) && cs && my_turn;
        mul_en   = (state_q == S_MUL);
        clip_en  = (state_q == S_CLIP);
    end

    assign last_ch = (ch_q == LAST_CH);

    // ---------------- preset selection ----------------
    assign key_rise = control_key1 && !key_q;

    always_comb begin
        preset_d = preset_q;
        if (key_rise) begin
            preset_d = OPT_W'(preset_next(int'(preset_q), NUM_PRESETS));
        end
    end

    always_comb begin
        cur_gain = '0;
        for (int i = 0; i < NUM_PRESETS; i++) begin
            if (preset_q == OPT_W'(i)) begin
                cur_gain = GAIN_TABLE[i*GAIN_W +: GAIN_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= 1'b0;
            preset_q <= '0;
        end else begin
            key_q    <= control_key1;
            preset_q <= preset_d;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        ch_d = ch_q;
        if (start_en) begin
            ch_d = '0;
        end else if (clip_en && !last_ch) begin
            ch_d = ch_q + 1'b1;
        end
    end

    // Gain is zero-extended so an all-ones entry still multiplies as positive.
    always_comb begin
        samp_ext = {{(PW-W){samp_q[ch_q][W-1]}}, samp_q[ch_q]};
        gain_ext = {{(PW-GAIN_W){1'b0}}, gain_q};
        prod_d   = samp_ext * gain_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_q <= '0;
            hard_q <= 1'b0;
            ch_q   <= '0;
            prod_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                samp_q[k] <= '0;
                dout_q[k] <= '0;
            end
        end else begin
            ch_q <= ch_d;
            if (start_en) begin
                gain_q <= cur_gain;
                hard_q <= hard_mode;
                for (int k = 0; k < NUM_CH; k++) begin
                    samp_q[k] <= data_in[k*W +: W];
                end
            end
            if (mul_en) begin
                prod_q <= prod_d;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (clip_en && (ch_q == CH_W'(k))) begin
                    dout_q[k] <= clip_y;
                end
            end
        end
    end

    dist_clip_core #(
        .W  (W),
        .PW (PW),
        .T  (THRESH)
    ) u_clip (
        .p_i    (prod_q),
        .hard_i (hard_q),
        .y_o    (clip_y)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign data_out[k*W +: W] = dout_q[k];
    end

    assign option_output     = preset_q;
    assign available_options = OPT_W'(NUM_PRESETS - 1);

endmodule
